// File: rtl/window_feature_pkg.sv
// window_feature_pkg: shared state encoding and width helpers for window_feature_extractor.
package window_feature_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int DEF_BITWIDTH = 8;
    localparam int DEF_WINDOW   = 8;
    localparam int SUM_W        = DEF_BITWIDTH + clog2(DEF_WINDOW);
    localparam int CNT_W        = clog2(DEF_WINDOW) + 1;

endpackage

// File: rtl/window_feature_extractor_signed_minmax.sv
// signed_minmax: combinational signed min of (a_min, b) and max of (a_max, b).
module signed_minmax #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a_min,
    input  logic signed [W-1:0] a_max,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] min_o,
    output logic signed [W-1:0] max_o
);

    always_comb begin
        min_o = (b < a_min) ? b : a_min;
        max_o = (b > a_max) ? b : a_max;
    end

endmodule

// File: rtl/window_feature_extractor.sv
// window_feature_extractor: per-window signed min/max/floor-mean over non-overlapping windows.
module window_feature_extractor
    import window_feature_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int WINDOW   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [BITWIDTH-1:0] signal_in,
    input  logic                       in_valid,
    input  logic                       clear,
    output logic signed [BITWIDTH-1:0] min_out,
    output logic signed [BITWIDTH-1:0] max_out,
    output logic signed [BITWIDTH-1:0] mean_out,
    output logic                       out_valid,
    output logic                       busy
);

    localparam int LG  = clog2(WINDOW);
    localparam int S_W = BITWIDTH + LG;
    localparam int C_W = LG + 1;

    state_e                     state_q, state_d;
    logic        [C_W-1:0]      cnt_q, cnt_d, cnt_nx;
    logic signed [BITWIDTH-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
    logic signed [S_W-1:0]      run_sum_q, run_sum_d, sum_nx;
    logic signed [BITWIDTH-1:0] min_q, min_d, max_q, max_d, mean_q, mean_d;
    logic signed [BITWIDTH-1:0] mm_min, mm_max, min_nx, max_nx;
    logic                       out_valid_q, out_valid_d;
    logic                       first;

    signed_minmax #(.W(BITWIDTH)) u_minmax (
        .a_min (run_min_q),
        .a_max (run_max_q),
        .b     (signal_in),
        .min_o (mm_min),
        .max_o (mm_max)
    );

    // A new window starts from the sample itself rather than from stale running values.
    assign first  = (state_q == IDLE);
    assign min_nx = first ? signal_in : mm_min;
    assign max_nx = first ? signal_in : mm_max;
    assign sum_nx = (first ? S_W'(0) : run_sum_q) + {{LG{signal_in[BITWIDTH-1]}}, signal_in};
    assign cnt_nx = first ? C_W'(1) : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_min_d   = run_min_q;
        run_max_d   = run_max_q;
        run_sum_d   = run_sum_q;
        min_d       = min_q;
        max_d       = max_q;
        mean_d      = mean_q;
        out_valid_d = 1'b0;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (in_valid) begin
            run_min_d = min_nx;
            run_max_d = max_nx;
            run_sum_d = sum_nx;
            if (cnt_nx == C_W'(WINDOW)) begin
                state_d     = IDLE;
                cnt_d       = '0;
                min_d       = min_nx;
                max_d       = max_nx;
                mean_d      = BITWIDTH'(sum_nx >>> LG);
                out_valid_d = 1'b1;
            end else begin
                state_d = ACCUM;
                cnt_d   = cnt_nx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            run_min_q   <= '0;
            run_max_q   <= '0;
            run_sum_q   <= '0;
            min_q       <= '0;
            max_q       <= '0;
            mean_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_min_q   <= run_min_d;
            run_max_q   <= run_max_d;
            run_sum_q   <= run_sum_d;
            min_q       <= min_d;
            max_q       <= max_d;
            mean_q      <= mean_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign min_out   = min_q;
    assign max_out   = max_q;
    assign mean_out  = mean_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ACCUM);

endmodule
